// File: rtl/loopback_mc_engine.sv
// loopback_mc_engine: bring-up / self-test datapath between the memory controller
// read FIFOs and the output-buffer FIFO. Pops stream and/or buffer words, combines
// them lane-wise (pass, saturating add, signed max) and pushes cfg_count results.
// Latency: pop at t, combined word in skid FIFO end of t+1, earliest push at t+2.
// Backpressure: a 2-entry skid FIFO plus one in-flight slot form a credit of 2;
// pops stop when credit is exhausted, so stream_write_ready low never loses data.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   start, cfg_mode,        start pulse (honoured in IDLE only) with mode and
//   cfg_count               word count latched on acceptance
//   busy, done              busy in RUN/DONE, one-cycle done pulse in DONE
//   stream_read_*           pop request / data / not-empty of the stream FIFO
//   buffer_read_*           pop request / data / not-empty of the buffer FIFO
//   stream_write_*          push request / data / not-full of the output buffer
//   *_count                 pops and pushes since the last accepted start
module loopback_mc_engine #(
  parameter int DATA_W     = 64,
  parameter int NUM_LANES  = 4,
  parameter int TX_COUNT_W = 20,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            cfg_mode,
  input  logic [TX_COUNT_W-1:0] cfg_count,
  output logic                  busy,
  output logic                  done,
  output logic                  stream_read_req,
  input  logic [DATA_W-1:0]     stream_read_data,
  input  logic                  stream_read_ready,
  output logic                  buffer_read_req,
  input  logic [DATA_W-1:0]     buffer_read_data,
  input  logic                  buffer_read_ready,
  output logic                  stream_write_req,
  output logic [DATA_W-1:0]     stream_write_data,
  input  logic                  stream_write_ready,
  output logic [CNT_W-1:0]      stream_read_count,
  output logic [CNT_W-1:0]      buffer_read_count,
  output logic [CNT_W-1:0]      write_count
);

  // DATA_W is expected to be an exact multiple of NUM_LANES.
  localparam int LANE_W = DATA_W / NUM_LANES;

  localparam logic [1:0] MODE_STREAM = 2'd0;
  localparam logic [1:0] MODE_BUFFER = 2'd1;
  localparam logic [1:0] MODE_ADD    = 2'd2;
  localparam logic [1:0] MODE_MAX    = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nxt;

  logic [1:0]              mode;
  logic [TX_COUNT_W-1:0]   count;
  logic [TX_COUNT_W-1:0]   issued;
  logic [TX_COUNT_W-1:0]   written;
  logic                    inflight;

  // 2-entry skid FIFO holding combined words waiting for the output buffer
  logic [DATA_W-1:0]       skid_mem [2];
  logic                    skid_rd;
  logic                    skid_wr;
  logic [1:0]              held;

  logic                    use_stream;
  logic                    use_buffer;
  logic                    src_ok;
  logic                    write_fire;
  logic [1:0]              occ;
  logic                    credit;
  logic                    pop;
  logic                    accept;

  logic [DATA_W-1:0]       add_word;
  logic [DATA_W-1:0]       max_word;
  logic [DATA_W-1:0]       combined;
  logic [LANE_W-1:0]       lane_a;
  logic [LANE_W-1:0]       lane_b;
  logic [LANE_W:0]         lane_sum;

  // ---------------------------------------------------------------------------
  // Pop / push decisions
  // ---------------------------------------------------------------------------
  assign use_stream = (mode != MODE_BUFFER);
  assign use_buffer = (mode != MODE_STREAM);
  assign src_ok     = (!use_stream || stream_read_ready) &&
                      (!use_buffer || buffer_read_ready);

  assign write_fire = (held != 2'd0) && stream_write_ready;

  // held + inflight never exceeds 2, so a 2-bit sum cannot wrap.
  assign occ    = held + {1'b0, inflight};
  // A full credit pool may still pop when the skid head leaves this cycle.
  assign credit = (occ < 2'd2) || ((occ == 2'd2) && write_fire);

  assign pop    = (state == S_RUN) && (issued < count) && src_ok && credit;
  assign accept = (state == S_IDLE) && start;

  assign stream_read_req   = pop && use_stream;
  assign buffer_read_req   = pop && use_buffer;
  assign stream_write_req  = write_fire;
  // Gate the head with occupancy so an empty skid shows zero, including after reset.
  assign stream_write_data = (held != 2'd0) ? skid_mem[skid_rd] : '0;

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // ---------------------------------------------------------------------------
  // Lane-wise combine of the data returned one cycle after a pop
  // ---------------------------------------------------------------------------
  always_comb begin
    add_word = '0;
    max_word = '0;
    lane_a   = '0;
    lane_b   = '0;
    lane_sum = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      lane_a   = stream_read_data[l*LANE_W +: LANE_W];
      lane_b   = buffer_read_data[l*LANE_W +: LANE_W];
      lane_sum = {lane_a[LANE_W-1], lane_a} + {lane_b[LANE_W-1], lane_b};
      // Overflow when the extended sign bit disagrees with the lane MSB.
      if (lane_sum[LANE_W] != lane_sum[LANE_W-1]) begin
        add_word[l*LANE_W +: LANE_W] = lane_sum[LANE_W] ? {1'b1, {(LANE_W-1){1'b0}}}
                                                        : {1'b0, {(LANE_W-1){1'b1}}};
      end else begin
        add_word[l*LANE_W +: LANE_W] = lane_sum[LANE_W-1:0];
      end
      max_word[l*LANE_W +: LANE_W] = ($signed(lane_a) >= $signed(lane_b)) ? lane_a : lane_b;
    end
  end

  always_comb begin
    combined = stream_read_data;
    case (mode)
      MODE_STREAM: combined = stream_read_data;
      MODE_BUFFER: combined = buffer_read_data;
      MODE_ADD:    combined = add_word;
      MODE_MAX:    combined = max_word;
      default:     combined = stream_read_data;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State machine
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (cfg_count == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        // Leave on the final push so DONE is the cycle after it.
        if (write_fire && ((written + TX_COUNT_W'(1)) == count)) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Configuration, progress counters, skid FIFO control
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      mode              <= MODE_STREAM;
      count             <= '0;
      issued            <= '0;
      written           <= '0;
      inflight          <= 1'b0;
      held              <= 2'd0;
      skid_rd           <= 1'b0;
      skid_wr           <= 1'b0;
      stream_read_count <= '0;
      buffer_read_count <= '0;
      write_count       <= '0;
    end else begin
      inflight <= pop;
      if (accept) begin
        mode              <= cfg_mode;
        count             <= cfg_count;
        issued            <= '0;
        written           <= '0;
        stream_read_count <= '0;
        buffer_read_count <= '0;
        write_count       <= '0;
      end else begin
        if (pop) begin
          issued <= issued + TX_COUNT_W'(1);
        end
        if (write_fire) begin
          written     <= written + TX_COUNT_W'(1);
          write_count <= write_count + CNT_W'(1);
        end
        if (stream_read_req) begin
          stream_read_count <= stream_read_count + CNT_W'(1);
        end
        if (buffer_read_req) begin
          buffer_read_count <= buffer_read_count + CNT_W'(1);
        end
      end
      if (inflight) begin
        skid_wr <= ~skid_wr;
      end
      if (write_fire) begin
        skid_rd <= ~skid_rd;
      end
      held <= held + {1'b0, inflight} - {1'b0, write_fire};
    end
  end

  // Storage only; occupancy and pointers above decide what is valid.
  always_ff @(posedge clk) begin
    if (inflight) begin
      skid_mem[skid_wr] <= combined;
    end
  end

endmodule

// File: tb/tb_loopback_mc_engine.sv
// Directed bench for loopback_mc_engine: models the two read FIFOs (data one
// cycle after a pop), captures pushes on the falling edge, and checks each
// scenario against hand-computed values.
module tb_loopback_mc_engine;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  cfg_mode = 2'd0;
  logic [19:0] cfg_count = '0;
  logic        busy, done;
  logic        stream_read_req, buffer_read_req, stream_write_req;
  logic [63:0] stream_read_data = '0;
  logic [63:0] buffer_read_data = '0;
  logic        stream_read_ready, buffer_read_ready;
  logic [63:0] stream_write_data;
  logic        wr_rdy = 1'b1;
  logic [31:0] stream_read_count, buffer_read_count, write_count;

  loopback_mc_engine #(.DATA_W(64), .NUM_LANES(4), .TX_COUNT_W(20), .CNT_W(32)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .cfg_mode          (cfg_mode),
    .cfg_count         (cfg_count),
    .busy              (busy),
    .done              (done),
    .stream_read_req   (stream_read_req),
    .stream_read_data  (stream_read_data),
    .stream_read_ready (stream_read_ready),
    .buffer_read_req   (buffer_read_req),
    .buffer_read_data  (buffer_read_data),
    .buffer_read_ready (buffer_read_ready),
    .stream_write_req  (stream_write_req),
    .stream_write_data (stream_write_data),
    .stream_write_ready(wr_rdy),
    .stream_read_count (stream_read_count),
    .buffer_read_count (buffer_read_count),
    .write_count       (write_count)
  );

  int n_total = 0;
  int n_pass  = 0;

  // ---------------- source FIFO models ----------------
  logic [63:0] s_mem [32];
  logic [63:0] b_mem [32];
  int          s_len = 0;
  int          b_len = 0;
  logic        s_en = 1'b0;
  logic        b_en = 1'b0;
  int          s_idx = 0;
  int          b_idx = 0;
  logic        m_clr = 1'b0;

  always @(posedge clk) begin
    if (m_clr) begin
      s_idx <= 0;
      b_idx <= 0;
    end else begin
      if (stream_read_req) begin
        stream_read_data <= s_mem[s_idx];
        s_idx <= s_idx + 1;
      end
      if (buffer_read_req) begin
        buffer_read_data <= b_mem[b_idx];
        b_idx <= b_idx + 1;
      end
    end
  end

  always_comb stream_read_ready = s_en && (s_idx < s_len);
  always_comb buffer_read_ready = b_en && (b_idx < b_len);

  // ---------------- output monitor ----------------
  logic [63:0] out_q [$];
  int          wr_cyc [$];
  int          cyc = 0;
  int          n_pop = 0;
  int          n_wr = 0;
  int          max_out = 0;
  int          done_cnt = 0;
  logic        mon_clr = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_clr) begin
      out_q.delete();
      wr_cyc.delete();
      n_pop = 0;
      n_wr = 0;
      max_out = 0;
      done_cnt = 0;
    end else begin
      if (stream_write_req) begin
        out_q.push_back(stream_write_data);
        wr_cyc.push_back(cyc);
        n_wr++;
      end
      if (stream_read_req || buffer_read_req) n_pop++;
      if (n_pop - n_wr > max_out) max_out = n_pop - n_wr;
      if (done) done_cnt++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- helpers (no checking inside) ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  // Clears the FIFO models and the monitor; returns on a falling edge.
  task automatic prep();
    @(negedge clk);
    m_clr = 1'b1;
    @(posedge clk);
    mon_clr = 1'b1;
    @(negedge clk);
    m_clr = 1'b0;
    @(posedge clk);
    mon_clr = 1'b0;
    @(negedge clk);
  endtask

  // Called on a falling edge; returns one falling edge later with start low.
  task automatic do_start(input logic [1:0] m, input logic [19:0] c);
    start = 1'b1;
    cfg_mode = m;
    cfg_count = c;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int k);
    k = 1;
    while (!done && k < bound) begin
      @(negedge clk);
      k++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    tick(); tick(); tick();
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else n_pass++;
    n_total++; if (stream_read_req !== 1'b0) $display("FAIL reset_sreq got=%b exp=0", stream_read_req); else n_pass++;
    n_total++; if (buffer_read_req !== 1'b0) $display("FAIL reset_breq got=%b exp=0", buffer_read_req); else n_pass++;
    n_total++; if (stream_write_req !== 1'b0) $display("FAIL reset_wreq got=%b exp=0", stream_write_req); else n_pass++;
    n_total++; if (stream_write_data !== 64'h0) $display("FAIL reset_wdata got=%h exp=0", stream_write_data); else n_pass++;
    n_total++; if (write_count !== 32'd0) $display("FAIL reset_wcnt got=%0d exp=0", write_count); else n_pass++;
    n_total++; if (stream_read_count !== 32'd0) $display("FAIL reset_scnt got=%0d exp=0", stream_read_count); else n_pass++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_stream();
    int k, c0;
    prep();
    for (int i = 0; i < 8; i++) s_mem[i] = 64'(i + 1);
    s_len = 8; s_en = 1'b1; b_len = 0; b_en = 1'b0; wr_rdy = 1'b1;
    c0 = cyc;
    do_start(2'd0, 20'd8);
    n_total++; if (busy !== 1'b1) $display("FAIL stream_busy_rise got=%b exp=1", busy); else n_pass++;
    wait_done(60, k);
    n_total++; if (done !== 1'b1) $display("FAIL stream_done_timeout got=%b exp=1", done); else n_pass++;
    n_total++; if (k !== 11) $display("FAIL stream_done_cycle got=%0d exp=11", k); else n_pass++;
    n_total++; if (write_count !== 32'd8) $display("FAIL stream_wcnt got=%0d exp=8", write_count); else n_pass++;
    n_total++; if (stream_read_count !== 32'd8) $display("FAIL stream_scnt got=%0d exp=8", stream_read_count); else n_pass++;
    n_total++; if (buffer_read_count !== 32'd0) $display("FAIL stream_bcnt got=%0d exp=0", buffer_read_count); else n_pass++;
    tick(); tick();
    n_total++; if (done_cnt !== 1) $display("FAIL stream_done_pulses got=%0d exp=1", done_cnt); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL stream_busy_fall got=%b exp=0", busy); else n_pass++;
    n_total++; if (out_q.size() !== 8) $display("FAIL stream_nwrites got=%0d exp=8", out_q.size()); else n_pass++;
    if (out_q.size() == 8) begin
      n_total++; if (wr_cyc[0] !== c0 + 3) $display("FAIL stream_first_latency got=%0d exp=%0d", wr_cyc[0], c0 + 3); else n_pass++;
      for (int i = 0; i < 8; i++) begin
        n_total++; if (out_q[i] !== 64'(i + 1)) $display("FAIL stream_data[%0d] got=%h exp=%h", i, out_q[i], 64'(i + 1)); else n_pass++;
        n_total++; if (wr_cyc[i] !== wr_cyc[0] + i) $display("FAIL stream_b2b[%0d] got=%0d exp=%0d", i, wr_cyc[i], wr_cyc[0] + i); else n_pass++;
      end
    end
  endtask

  task automatic test_add();
    int k;
    prep();
    s_mem[0] = 64'hFFFF_0001_8000_7FF0; b_mem[0] = 64'h0001_0002_FFFF_0020;
    s_mem[1] = 64'h7FFF_8000_0005_FFFE; b_mem[1] = 64'h7FFF_8000_FFFB_FFFE;
    s_len = 2; b_len = 2; s_en = 1'b1; b_en = 1'b1; wr_rdy = 1'b1;
    do_start(2'd2, 20'd2);
    wait_done(40, k);
    n_total++; if (done !== 1'b1) $display("FAIL add_done_timeout got=%b exp=1", done); else n_pass++;
    n_total++; if (out_q.size() !== 2) $display("FAIL add_nwrites got=%0d exp=2", out_q.size()); else n_pass++;
    if (out_q.size() == 2) begin
      n_total++; if (out_q[0] !== 64'h0000_0003_8000_7FFF) $display("FAIL add_sat0 got=%h exp=0000000380007fff", out_q[0]); else n_pass++;
      n_total++; if (out_q[1] !== 64'h7FFF_8000_0000_FFFC) $display("FAIL add_sat1 got=%h exp=7fff80000000fffc", out_q[1]); else n_pass++;
    end
    n_total++; if (buffer_read_count !== 32'd2) $display("FAIL add_bcnt got=%0d exp=2", buffer_read_count); else n_pass++;
    tick();
  endtask

  task automatic test_max();
    int k, bad;
    logic [63:0] exp_w [4];
    prep();
    s_mem[0] = 64'h0001_FFFF_8000_7FFF; b_mem[0] = 64'h0000_0001_7FFF_8000; exp_w[0] = 64'h0001_0001_7FFF_7FFF;
    s_mem[1] = 64'h1234_1234_FFFE_0010; b_mem[1] = 64'h1234_1235_FFFF_0020; exp_w[1] = 64'h1234_1235_FFFF_0020;
    s_mem[2] = 64'h8000_8001_0000_0000; b_mem[2] = 64'h8001_8000_FFFF_0001; exp_w[2] = 64'h8001_8001_0000_0001;
    s_mem[3] = 64'h0A0A_0B0B_0C0C_0D0D; b_mem[3] = 64'h0B0B_0A0A_0D0D_0C0C; exp_w[3] = 64'h0B0B_0B0B_0D0D_0D0D;
    s_len = 4; b_len = 4; s_en = 1'b1; b_en = 1'b0; wr_rdy = 1'b1;
    do_start(2'd3, 20'd4);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (stream_read_req || buffer_read_req) bad++;
      tick();
    end
    n_total++; if (bad !== 0) $display("FAIL max_no_pop_when_empty got=%0d pops exp=0", bad); else n_pass++;
    b_en = 1'b1;
    wait_done(40, k);
    n_total++; if (done !== 1'b1) $display("FAIL max_done_timeout got=%b exp=1", done); else n_pass++;
    n_total++; if (out_q.size() !== 4) $display("FAIL max_nwrites got=%0d exp=4", out_q.size()); else n_pass++;
    if (out_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        n_total++; if (out_q[i] !== exp_w[i]) $display("FAIL max_data[%0d] got=%h exp=%h", i, out_q[i], exp_w[i]); else n_pass++;
      end
    end
    n_total++; if (stream_read_count !== 32'd4) $display("FAIL max_scnt got=%0d exp=4", stream_read_count); else n_pass++;
    n_total++; if (buffer_read_count !== 32'd4) $display("FAIL max_bcnt got=%0d exp=4", buffer_read_count); else n_pass++;
    tick();
  endtask

  task automatic test_backpressure();
    int k, p;
    prep();
    for (int i = 0; i < 16; i++) b_mem[i] = 64'hB000_0000_0000_0000 | 64'(i * 17 + 3);
    b_len = 16; b_en = 1'b1; s_len = 0; s_en = 1'b0; wr_rdy = 1'b1;
    do_start(2'd1, 20'd16);
    k = 1; p = 0;
    while (!done && k < 200) begin
      wr_rdy = ((p % 4) == 0) || ((p % 4) == 3);
      tick();
      p++; k++;
    end
    wr_rdy = 1'b1;
    n_total++; if (done !== 1'b1) $display("FAIL bp_done_timeout got=%b exp=1", done); else n_pass++;
    n_total++; if (max_out > 2) $display("FAIL bp_outstanding got=%0d exp<=2", max_out); else n_pass++;
    n_total++; if (max_out !== 2) $display("FAIL bp_skid_filled got=%0d exp=2", max_out); else n_pass++;
    n_total++; if (write_count !== 32'd16) $display("FAIL bp_wcnt got=%0d exp=16", write_count); else n_pass++;
    n_total++; if (buffer_read_count !== 32'd16) $display("FAIL bp_bcnt got=%0d exp=16", buffer_read_count); else n_pass++;
    n_total++; if (stream_read_count !== 32'd0) $display("FAIL bp_scnt got=%0d exp=0", stream_read_count); else n_pass++;
    n_total++; if (out_q.size() !== 16) $display("FAIL bp_nwrites got=%0d exp=16", out_q.size()); else n_pass++;
    if (out_q.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        n_total++;
        if (out_q[i] !== (64'hB000_0000_0000_0000 | 64'(i * 17 + 3)))
          $display("FAIL bp_data[%0d] got=%h exp=%h", i, out_q[i], 64'hB000_0000_0000_0000 | 64'(i * 17 + 3));
        else n_pass++;
      end
    end
    tick();
  endtask

  task automatic test_zero_count();
    do_start(2'd0, 20'd0);
    n_total++; if (done !== 1'b1) $display("FAIL zero_done got=%b exp=1", done); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL zero_busy got=%b exp=1", busy); else n_pass++;
    n_total++; if (stream_read_req !== 1'b0) $display("FAIL zero_sreq got=%b exp=0", stream_read_req); else n_pass++;
    n_total++; if (write_count !== 32'd0) $display("FAIL zero_wcnt got=%0d exp=0", write_count); else n_pass++;
    n_total++; if (buffer_read_count !== 32'd0) $display("FAIL zero_bcnt got=%0d exp=0", buffer_read_count); else n_pass++;
    n_total++; if (stream_read_count !== 32'd0) $display("FAIL zero_scnt got=%0d exp=0", stream_read_count); else n_pass++;
    tick();
    n_total++; if (done !== 1'b0) $display("FAIL zero_done_fall got=%b exp=0", done); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL zero_busy_fall got=%b exp=0", busy); else n_pass++;
  endtask

  task automatic test_start_in_run();
    int k;
    prep();
    for (int i = 0; i < 6; i++) s_mem[i] = 64'h5000 + 64'(i);
    s_len = 6; s_en = 1'b1; b_len = 0; b_en = 1'b0; wr_rdy = 1'b1;
    do_start(2'd0, 20'd6);
    tick(); tick();
    start = 1'b1; cfg_mode = 2'd1; cfg_count = 20'd2;
    tick();
    start = 1'b0;
    wait_done(40, k);
    n_total++; if (done !== 1'b1) $display("FAIL sir_done_timeout got=%b exp=1", done); else n_pass++;
    n_total++; if (write_count !== 32'd6) $display("FAIL sir_wcnt got=%0d exp=6", write_count); else n_pass++;
    n_total++; if (buffer_read_count !== 32'd0) $display("FAIL sir_bcnt got=%0d exp=0", buffer_read_count); else n_pass++;
    n_total++; if (out_q.size() !== 6) $display("FAIL sir_nwrites got=%0d exp=6", out_q.size()); else n_pass++;
    if (out_q.size() == 6) begin
      n_total++; if (out_q[5] !== 64'h5005) $display("FAIL sir_last got=%h exp=5005", out_q[5]); else n_pass++;
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int k;
    prep();
    for (int i = 0; i < 10; i++) s_mem[i] = 64'hA0 + 64'(i);
    s_len = 10; s_en = 1'b1; b_len = 0; b_en = 1'b0; wr_rdy = 1'b1;
    do_start(2'd0, 20'd10);
    repeat (6) tick();
    reset = 1'b1;
    tick();
    n_total++; if (out_q.size() !== 5) $display("FAIL rmid_writes_before got=%0d exp=5", out_q.size()); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rmid_busy got=%b exp=0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL rmid_done got=%b exp=0", done); else n_pass++;
    n_total++; if (stream_read_req !== 1'b0) $display("FAIL rmid_sreq got=%b exp=0", stream_read_req); else n_pass++;
    n_total++; if (stream_write_req !== 1'b0) $display("FAIL rmid_wreq got=%b exp=0", stream_write_req); else n_pass++;
    n_total++; if (stream_write_data !== 64'h0) $display("FAIL rmid_wdata got=%h exp=0", stream_write_data); else n_pass++;
    n_total++; if (write_count !== 32'd0) $display("FAIL rmid_wcnt got=%0d exp=0", write_count); else n_pass++;
    n_total++; if (stream_read_count !== 32'd0) $display("FAIL rmid_scnt got=%0d exp=0", stream_read_count); else n_pass++;
    reset = 1'b0;
    prep();
    do_start(2'd0, 20'd3);
    wait_done(40, k);
    n_total++; if (done !== 1'b1) $display("FAIL rmid_done_timeout got=%b exp=1", done); else n_pass++;
    n_total++; if (write_count !== 32'd3) $display("FAIL rmid_restart_wcnt got=%0d exp=3", write_count); else n_pass++;
    n_total++; if (out_q.size() !== 3) $display("FAIL rmid_restart_nwrites got=%0d exp=3", out_q.size()); else n_pass++;
    if (out_q.size() == 3) begin
      n_total++; if (out_q[0] !== 64'hA0) $display("FAIL rmid_restart_first got=%h exp=a0", out_q[0]); else n_pass++;
      n_total++; if (out_q[2] !== 64'hA2) $display("FAIL rmid_restart_last got=%h exp=a2", out_q[2]); else n_pass++;
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_add();
    test_max();
    test_backpressure();
    test_zero_count();
    test_start_in_run();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
